mfx_control_sequencer: RTL
==========================

Name: mfx_control_sequencer

Overview:
- Moore control sequencer for the Mini SRC datapath.
- Generates the per-cycle strobes for instruction fetch (T0–T2) and one execute step (T3) for the special-register move instructions: mfhi, mflo, mthi, mtlo.
- Memory read latency is parametrised.
- Supports single-step (one instruction per start pulse) and free-run operation, with busy/done status.
- Sits between the instruction register opcode field and the datapath enable/out inputs; replaces hand-sequenced bench stimulus.

Parameters:
- OP_W, 5, opcode width (IR[31:27]).
- MEM_LAT, 1, cycles Read/MDRen are held in T1; legal range 1..15.
- CNT_W, 4, width of the T1 wait counter; must satisfy 2**CNT_W > MEM_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- start  in  1  begin one instruction when idle.
- run  in  1  free-run mode; sampled at end of T3.
- ir_opcode  in  OP_W  IR opcode field; valid from the T3 cycle onward.
- Pout, MARen, PCinc  out  1  T0 strobes.
- Read, MDRen  out  1  T1 strobes.
- MDROut, IRen  out  1  T2 strobes.
- Gra, Rin, Rout, HIout, LOout, HIen, LOen  out  1  T3 strobes.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in T3.
- illegal  out  1  one-cycle pulse in T3 for an unsupported opcode.
- state  out  3  encoded present state, for debug.

Behaviour:
- States: IDLE=0, T0=1, T1=2, T2=3, T3=4. The state register and the wait counter are the only flops. All outputs decode combinationally from the registered state and ir_opcode.
- Reset: on a clk edge with clr=1, state←IDLE and counter←0. clr has priority over start and run. All outputs are 0 in IDLE, so every strobe is low in the cycle after the reset edge. Reset mid-instruction abandons it; no done or illegal pulse is produced.
- IDLE: start=1 → T0; otherwise stay in IDLE.
- T0 (1 cycle): Pout=MARen=PCinc=1. Next state T1; counter←0.
- T1 (MEM_LAT cycles): Read=MDRen=1. Counter increments each cycle. Leave for T2 on the cycle where counter==MEM_LAT-1.
- T2 (1 cycle): MDROut=IRen=1. Next state T3.
- T3 (1 cycle): done=1. Strobes by opcode:
  - mfhi: Gra, Rin, HIout.
  - mflo: Gra, Rin, LOout.
  - mthi: Gra, Rout, HIen.
  - mtlo: Gra, Rout, LOen.
  - Any other opcode: illegal=1 and no datapath strobe asserted.
- Leaving T3: run=1 → T0; otherwise IDLE.
- Instruction latency: MEM_LAT+3 cycles from T0 to the end of T3. In free-run, consecutive T0s are exactly MEM_LAT+3 cycles apart.
- start is ignored while busy=1; it is not queued. start and run held high from IDLE behave as free-run from the first T0.
- Bus-driver exclusivity: at most one of Pout, MDROut, HIout, LOout, Rout is high in any cycle. This is invariant for all opcode inputs.
- ir_opcode is don't-care outside T3. T3 outputs must not depend on it in any other state.
- Unreachable state encodings 5..7 → IDLE on the next edge, with all outputs 0.

Decomposition:
- Package mfx_pkg holds:
  - State encodings IDLE..T3.
  - OP_MFHI=5'b10111, OP_MFLO=5'b11000, OP_MTHI=5'b10101, OP_MTLO=5'b10110.
  - Constant STATE_W=3.
- One sub-module, mfx_t3_decode: purely combinational, maps (state==T3, ir_opcode) to the seven T3 strobes plus illegal.

Test Plan:
- Reset: clr=1 for 2 cycles with start=1 → state=0, busy=0, all strobes 0. First T0 appears on the edge after clr falls.
- Single mfhi, MEM_LAT=1: start pulse, ir_opcode=5'b10111 → T0,T1,T2,T3 on four consecutive cycles. T3 shows Gra=Rin=HIout=1 and done=1, then IDLE with busy=0.
- MEM_LAT=3, mtlo: Read=MDRen held exactly 3 cycles. T3 shows Gra=Rout=LOen=1. Total busy time is 6 cycles.
- Free-run: run=1, alternating mflo/mthi opcodes → done pulses every MEM_LAT+3 cycles. T3 strobes match each opcode; no IDLE cycle appears between instructions.
- Illegal opcode 5'b00000 in T3 → illegal=1 for 1 cycle, no datapath strobes asserted, done=1, normal return to IDLE.
- clr asserted during T1 (MEM_LAT=3, second wait cycle) → IDLE on the next edge. No done or illegal pulse occurs, and a subsequent start fetches normally. The bus-exclusivity assertion holds throughout every scenario.

Source files
------------

// File: rtl/mfx_pkg.sv
// mfx_pkg: shared state encodings and opcode constants for the Mini SRC move sequencer
package mfx_pkg;
   localparam int STATE_W = 3;
   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'd0,
      T0   = 3'd1,
      T1   = 3'd2,
      T2   = 3'd3,
      T3   = 3'd4
   } state_t;
   localparam logic [4:0] OP_MFHI = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000;
   localparam logic [4:0] OP_MTHI = 5'b10101;
   localparam logic [4:0] OP_MTLO = 5'b10110;
endpackage

// File: rtl/mfx_t3_decode.sv
// mfx_t3_decode: combinational execute-step strobes for mfhi/mflo/mthi/mtlo
module mfx_t3_decode
   import mfx_pkg::*;
#(
   parameter int OP_W = 5
)(
   input  logic            i_t3,
   input  logic [OP_W-1:0] i_opcode,
   output logic            o_gra,
   output logic            o_rin,
   output logic            o_rout,
   output logic            o_hiout,
   output logic            o_loout,
   output logic            o_hien,
   output logic            o_loen,
   output logic            o_illegal
);
   logic w_mfhi, w_mflo, w_mthi, w_mtlo, w_legal;
   assign w_mfhi    = i_opcode == OP_W'(OP_MFHI);
   assign w_mflo    = i_opcode == OP_W'(OP_MFLO);
   assign w_mthi    = i_opcode == OP_W'(OP_MTHI);
   assign w_mtlo    = i_opcode == OP_W'(OP_MTLO);
   assign w_legal   = w_mfhi | w_mflo | w_mthi | w_mtlo;
   assign o_gra     = i_t3 & w_legal;
   assign o_rin     = i_t3 & (w_mfhi | w_mflo);
   assign o_rout    = i_t3 & (w_mthi | w_mtlo);
   assign o_hiout   = i_t3 & w_mfhi;
   assign o_loout   = i_t3 & w_mflo;
   assign o_hien    = i_t3 & w_mthi;
   assign o_loen    = i_t3 & w_mtlo;
   assign o_illegal = i_t3 & ~w_legal;
endmodule

// File: rtl/mfx_control_sequencer.sv
// mfx_control_sequencer: Moore fetch/execute strobe sequencer for Mini SRC special-register moves
module mfx_control_sequencer
   import mfx_pkg::*;
#(
   parameter int OP_W    = 5,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 4
)(
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic               run,
   input  logic [OP_W-1:0]    ir_opcode,
   output logic               Pout,
   output logic               MARen,
   output logic               PCinc,
   output logic               Read,
   output logic               MDRen,
   output logic               MDROut,
   output logic               IRen,
   output logic               Gra,
   output logic               Rin,
   output logic               Rout,
   output logic               HIout,
   output logic               LOout,
   output logic               HIen,
   output logic               LOen,
   output logic               busy,
   output logic               done,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_t0, w_t1, w_t2, w_t3;
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: if (start) r_state <= T0;
            T0: begin
               r_state <= T1;
               r_cnt   <= '0;
            end
            T1: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(MEM_LAT - 1)) r_state <= T2;
            end
            T2: r_state <= T3;
            T3: r_state <= run ? T0 : IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
   assign w_t0   = r_state == T0;
   assign w_t1   = r_state == T1;
   assign w_t2   = r_state == T2;
   assign w_t3   = r_state == T3;
   assign Pout   = w_t0;
   assign MARen  = w_t0;
   assign PCinc  = w_t0;
   assign Read   = w_t1;
   assign MDRen  = w_t1;
   assign MDROut = w_t2;
   assign IRen   = w_t2;
   // unreachable encodings fall outside every decode, so they read as not busy
   assign busy   = w_t0 | w_t1 | w_t2 | w_t3;
   assign done   = w_t3;
   assign state  = r_state;
   mfx_t3_decode #(.OP_W(OP_W)) u_t3 (
      .i_t3      (w_t3),
      .i_opcode  (ir_opcode),
      .o_gra     (Gra),
      .o_rin     (Rin),
      .o_rout    (Rout),
      .o_hiout   (HIout),
      .o_loout   (LOout),
      .o_hien    (HIen),
      .o_loen    (LOen),
      .o_illegal (illegal)
   );
endmodule
